game_controller: RTL

//  Top-level game-flow FSM. Consumes obstacle positions/types and dino height,

---
 rtl/game_controller_if.sv | 31 +++
 rtl/game_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/game_controller_if.sv
// Groups the game controller's stimulus inputs and status outputs into one bundle.
// Ports: btn_jump, dino_y, obstacleN_pos/type in; game_start, game_frozen,
//        game_over, collision, score, hi_score out (from the controller's view).
interface game_controller_if #(
  parameter int CONV = 0
);
  logic             btn_jump;
  logic [5:0]       dino_y;
  logic [9:CONV]    obstacle1_pos;
  logic [9:CONV]    obstacle2_pos;
  logic [2:0]       obstacle1_type;
  logic [2:0]       obstacle2_type;
  logic             game_start;
  logic             game_frozen;
  logic             game_over;
  logic             collision;
  logic [15:0]      score;
  logic [15:0]      hi_score;

  // master: the environment (button, dino, obstacle generator side)
  modport master (
    output btn_jump, dino_y, obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type,
    input  game_start, game_frozen, game_over, collision, score, hi_score
  );

  // slave: the game controller itself
  modport slave (
    input  btn_jump, dino_y, obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type,
    output game_start, game_frozen, game_over, collision, score, hi_score
  );
endinterface

// File: rtl/game_controller.sv
// Game-flow FSM: synchronises the jump button, runs hitbox collision against two
// obstacles, keeps a saturating 4-digit BCD score and drives start/frozen/over status.
// Ports: clk, rst (async, active-high), gi (game_controller_if.slave).
// Optional HISCORE_EN macro: keeps a best-score register latched on each death;
// without it hi_score is tied to zero.
module game_controller #(
  parameter int CONV      = 0,
  parameter int DINO_X    = 40,
  parameter int DINO_W    = 16,
  parameter int OBS_W     = 12,
  parameter int CACTUS_H  = 20,
  parameter int BIRD_LO   = 16,
  parameter int BIRD_HI   = 40,
  parameter int SCORE_DIV = 6,
  parameter int HIT_HOLD  = 60
) (
  input  logic             clk,
  input  logic             rst,
  game_controller_if.slave gi
);

  localparam int PW       = 10 - CONV;
  localparam int DIV_W    = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_W   = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HIT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_HIT,
    S_OVER
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               btn_s1;
  logic               btn_s2;
  logic               btn_s3;
  logic               press;
  logic               collision_q;
  logic               hit1;
  logic               hit2;
  logic [DIV_W-1:0]   div_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [15:0]        score_q;
  logic               game_start;
  logic               game_frozen;
  logic               game_over;

  // Positions are widened to 11 bits so pos + OBS_W cannot wrap.
  function automatic logic obs_hit(input logic [10:0] pos, input logic [2:0] typ,
                                   input logic [5:0] y);
    logic x_ovl;
    logic y_ovl;
    x_ovl = (pos != '0) && ((pos + 11'(OBS_W)) > 11'(DINO_X)) &&
            (pos < 11'(DINO_X + DINO_W));
    if (typ[2]) begin
      y_ovl = ({1'b0, y} >= 7'(BIRD_LO)) && ({1'b0, y} < 7'(BIRD_HI));
    end else begin
      y_ovl = {1'b0, y} < 7'(CACTUS_H);
    end
    return x_ovl && y_ovl;
  endfunction

  // Per-digit BCD increment; 9999 holds rather than wrapping to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = (v != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign hit1  = obs_hit({{(11-PW){1'b0}}, gi.obstacle1_pos}, gi.obstacle1_type, gi.dino_y);
  assign hit2  = obs_hit({{(11-PW){1'b0}}, gi.obstacle2_pos}, gi.obstacle2_type, gi.dino_y);
  // btn_s2 is the synchronised level; btn_s3 is its previous value for edge detect.
  assign press = btn_s2 & ~btn_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    game_start  = 1'b0;
    game_frozen = 1'b1;
    game_over   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_START;
      end
      S_START: begin
        game_start = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        game_frozen = 1'b0;
        if (collision_q) state_d = S_HIT;
      end
      S_HIT: begin
        game_over = 1'b1;
        if (hold_q == HOLD_LAST) state_d = S_OVER;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (press) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_s3      <= 1'b0;
      collision_q <= 1'b0;
      div_q       <= '0;
      hold_q      <= '0;
      score_q     <= 16'h0000;
    end else begin
      btn_s1      <= gi.btn_jump;
      btn_s2      <= btn_s1;
      btn_s3      <= btn_s2;
      collision_q <= hit1 | hit2;
      case (state_q)
        S_START: begin
          score_q <= 16'h0000;
          div_q   <= '0;
        end
        S_RUN: begin
          // Hold counter is cleared here so HIT always starts counting from zero.
          hold_q <= '0;
          // A collision on the tick cycle suppresses that tick.
          if (!collision_q) begin
            if (div_q == DIV_LAST) begin
              div_q   <= '0;
              score_q <= bcd_inc(score_q);
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        S_HIT: begin
          if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HISCORE_EN
  logic [15:0] hi_q;

  // Valid BCD orders the same as binary, so a plain magnitude compare suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 16'h0000;
    end else if ((state_q == S_RUN) && collision_q && (score_q > hi_q)) begin
      hi_q <= score_q;
    end
  end

  assign gi.hi_score = hi_q;
`else
  assign gi.hi_score = 16'h0000;
`endif

  assign gi.game_start  = game_start;
  assign gi.game_frozen = game_frozen;
  assign gi.game_over   = game_over;
  assign gi.collision   = collision_q;
  assign gi.score       = score_q;

endmodule
